// File: rtl/uart9_rx.sv
// Receiver for the 9-bit UART link (start, 9 data LSB first, 1 stop, idle high).
// Delivers framed words through a valid/ready holding register with frame and overrun flags.
module uart9_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [8:0] data9,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      idx_q;
  logic [8:0]      shreg_q;
  logic            rx_meta_q;
  logic            rx_s_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      data9      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A deliver later in this block overrides the accept-clear.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s_q) begin
              state_q <= StData;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s_q, shreg_q[8:1]};
            if (idx_q == 4'd8) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            busy  <= 1'b0;
            if (rx_s_q) begin
              state_q <= StIdle;
              if (!data_valid || data_ready) begin
                data9      <= shreg_q;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state_q   <= StWaitIdle;
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitIdle: begin
          if (rx_s_q) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart9_rx.sv
// Self-checking bench for uart9_rx: table of frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_uart9_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] data9;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int         n_hs, n_vcyc, n_ferr, n_ovr, n_busy, n_both;
  logic [8:0] got_q[$];

  uart9_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data9     (data9),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Outputs observed on the falling edge; inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (data_valid) n_vcyc++;
    if (data_valid && data_ready) begin
      n_hs++;
      got_q.push_back(data9);
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (busy) n_busy++;
    if (frame_err && overrun) n_both++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr_mon();
    n_hs = 0; n_vcyc = 0; n_ferr = 0; n_ovr = 0; n_busy = 0;
    got_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(DIV);
  endtask

  task automatic send_frame(input logic [8:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 9; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  function automatic int word_at(input int i);
    return (got_q.size() > i) ? int'(got_q[i]) : -1;
  endfunction

  typedef struct {
    logic [8:0] d;
    logic       stop;
    int         exp_hs;
    int         exp_vcyc;
    logic [8:0] exp_word;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  logic [8:0] exp_q[$];
  int         exp_ferr_r;

  initial begin
    vecs[0] = '{d: 9'h1A5, stop: 1'b1, exp_hs: 1, exp_vcyc: 1, exp_word: 9'h1A5, exp_ferr: 0};
    vecs[1] = '{d: 9'h000, stop: 1'b1, exp_hs: 1, exp_vcyc: 1, exp_word: 9'h000, exp_ferr: 0};
    vecs[2] = '{d: 9'h1FF, stop: 1'b1, exp_hs: 1, exp_vcyc: 1, exp_word: 9'h1FF, exp_ferr: 0};
    vecs[3] = '{d: 9'h0FF, stop: 1'b0, exp_hs: 0, exp_vcyc: 0, exp_word: 9'h000, exp_ferr: 1};
    vecs[4] = '{d: 9'h155, stop: 1'b1, exp_hs: 1, exp_vcyc: 1, exp_word: 9'h155, exp_ferr: 0};
    n_both = 0;
    clr_mon();

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst data9", int'(data9), 0);
    check("rst valid", int'(data_valid), 0);
    check("rst ferr", int'(frame_err), 0);
    check("rst ovr", int'(overrun), 0);
    check("rst busy", int'(busy), 0);
    reset_n = 1'b1;
    tick(2 * DIV);

    // Table of single frames, ready held high
    for (int v = 0; v < 5; v++) begin
      clr_mon();
      send_frame(vecs[v].d, vecs[v].stop);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check($sformatf("vec%0d handshakes", v), n_hs, vecs[v].exp_hs);
      check($sformatf("vec%0d valid cycles", v), n_vcyc, vecs[v].exp_vcyc);
      check($sformatf("vec%0d frame_err", v), n_ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d overrun", v), n_ovr, 0);
      if (vecs[v].exp_hs > 0) check($sformatf("vec%0d word", v), word_at(0),
                                    int'(vecs[v].exp_word));
    end

    // Short low glitch: busy pulses, then back to idle, no frame
    clr_mon();
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(2 * DIV);
    check("glitch busy seen", int'(n_busy > 0 && n_busy < DIV), 1);
    check("glitch busy end", int'(busy), 0);
    check("glitch valid", n_vcyc, 0);
    check("glitch ferr", n_ferr, 0);

    // Bad stop, held-low break, then a good frame
    clr_mon();
    send_frame(9'h0FF, 1'b0);
    rx = 1'b0;
    tick(5 * DIV);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(9'h100, 1'b1);
    drive_bit(1'b1);
    check("break ferr", n_ferr, 1);
    check("break handshakes", n_hs, 1);
    check("break word", word_at(0), 'h100);
    check("break ovr", n_ovr, 0);

    // Overrun: consumer stalled across two frames
    clr_mon();
    data_ready = 1'b0;
    send_frame(9'h001, 1'b1);
    drive_bit(1'b1);
    send_frame(9'h1FE, 1'b1);
    drive_bit(1'b1);
    check("ovr valid", int'(data_valid), 1);
    check("ovr data9", int'(data9), 'h001);
    check("ovr pulses", n_ovr, 1);
    check("ovr ferr", n_ferr, 0);
    data_ready = 1'b1;
    tick(1);
    check("ovr drop valid", int'(data_valid), 0);
    check("ovr data9 kept", int'(data9), 'h001);
    check("ovr accepted word", word_at(0), 'h001);

    // Reset during data bit 4
    clr_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx = 1'b1;
    tick(DIV / 2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid rst valid", int'(data_valid), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst data9", int'(data9), 0);
    check("mid rst ferr", int'(frame_err), 0);
    check("mid rst ovr", int'(overrun), 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(9'h0AA, 1'b1);
    drive_bit(1'b1);
    check("post rst handshakes", n_hs, 1);
    check("post rst word", word_at(0), 'h0AA);
    check("post rst ferr", n_ferr, 0);
    check("post rst ovr", n_ovr, 0);

    // Back-to-back frames with no idle gap
    clr_mon();
    send_frame(9'h155, 1'b1);
    send_frame(9'h0AA, 1'b1);
    drive_bit(1'b1);
    check("b2b handshakes", n_hs, 2);
    check("b2b word0", word_at(0), 'h155);
    check("b2b word1", word_at(1), 'h0AA);
    check("b2b ferr", n_ferr, 0);
    check("b2b ovr", n_ovr, 0);

    // Random frames against the frame-level model
    clr_mon();
    exp_q.delete();
    exp_ferr_r = 0;
    for (int f = 0; f < 24; f++) begin
      logic [8:0] d;
      logic       s;
      int         gap;
      d   = 9'($urandom_range(0, 511));
      s   = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 2);
      if (!s && gap == 0) gap = 1;
      send_frame(d, s);
      if (s) exp_q.push_back(d);
      else exp_ferr_r++;
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    check("rand count", n_hs, exp_q.size());
    check("rand ferr", n_ferr, exp_ferr_r);
    check("rand ovr", n_ovr, 0);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand word%0d", i), word_at(i), int'(exp_q[i]));

    check("ferr with ovr", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
